// File: rtl/adder_seq.sv
// adder_seq: multi-cycle adder/subtractor that adds one CHUNK-bit slice per clock,
// LSB slice first, and publishes the registered result with a one-cycle done pulse.
// Optional build macro ADDER_SEQ_SAT_EN: saturate ans on signed overflow instead of
// wrapping; cout and ovf are reported either way.
module adder_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic [WIDTH-1:0] ans,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} stateT;

  stateT             stateQ, stateD;
  logic [WIDTH-1:0]  opAQ, opBQ;    // operands, shifted right one slice per cycle
  logic [WIDTH-1:0]  partQ;         // finished slices accumulate from the top down
  logic              carryQ;
  logic [CntW-1:0]   cntQ;
  logic              msbAQ, msbBQ;  // effective operand sign bits for overflow
  logic [WIDTH-1:0]  ansQ;
  logic              coutQ, ovfQ;

  logic              accept;
  logic              lastSlice;
  logic [CHUNK:0]    sliceSum;
  logic [WIDTH-1:0]  sumFull;
  logic              resOvf;
  logic [WIDTH-1:0]  resAns;

  // Accept new work in IDLE or DONE only; a start during BUSY is dropped.
  assign accept    = start && (stateQ != StBusy);
  assign lastSlice = (cntQ == CntW'(N - 1));

  // Slice adder plus the full-width view of the sum once this slice is merged in.
  always_comb begin
    sliceSum = {1'b0, opAQ[CHUNK-1:0]} + {1'b0, opBQ[CHUNK-1:0]}
             + {{CHUNK{1'b0}}, carryQ};
    sumFull  = (partQ >> CHUNK) | (WIDTH'(sliceSum[CHUNK-1:0]) << (WIDTH - CHUNK));
    resOvf   = (msbAQ == msbBQ) && (sumFull[WIDTH-1] != msbAQ);
`ifdef ADDER_SEQ_SAT_EN
    if (resOvf) begin
      // Both operands negative -> clamp to most negative, else most positive.
      resAns = msbAQ ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      resAns = sumFull;
    end
`else
    resAns = sumFull;
`endif
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state logic.
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle:  if (start) stateD = StBusy;
      StBusy:  if (lastSlice) stateD = StDone;
      StDone:  stateD = start ? StBusy : StIdle;
      default: stateD = StIdle;
    endcase
  end

  // Status outputs decoded straight from the state.
  always_comb begin
    busy = (stateQ == StBusy);
    done = (stateQ == StDone);
  end

  // Datapath: latch operands on accept, add one slice per BUSY cycle, publish at the end.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opAQ   <= '0;
      opBQ   <= '0;
      partQ  <= '0;
      carryQ <= 1'b0;
      cntQ   <= '0;
      msbAQ  <= 1'b0;
      msbBQ  <= 1'b0;
      ansQ   <= '0;
      coutQ  <= 1'b0;
      ovfQ   <= 1'b0;
    end else if (accept) begin
      // Subtraction is inA + ~inB + 1, the +1 entering as the first carry-in.
      opAQ   <= inA;
      opBQ   <= sub ? ~inB : inB;
      partQ  <= '0;
      carryQ <= sub;
      cntQ   <= '0;
      msbAQ  <= inA[WIDTH-1];
      msbBQ  <= inB[WIDTH-1] ^ sub;
    end else if (stateQ == StBusy) begin
      opAQ   <= opAQ >> CHUNK;
      opBQ   <= opBQ >> CHUNK;
      partQ  <= sumFull;
      carryQ <= sliceSum[CHUNK];
      cntQ   <= cntQ + CntW'(1);
      if (lastSlice) begin
        ansQ  <= resAns;
        coutQ <= sliceSum[CHUNK];
        ovfQ  <= resOvf;
      end
    end
  end

  assign ans  = ansQ;
  assign cout = coutQ;
  assign ovf  = ovfQ;

endmodule

// File: tb/tb_adder_seq.sv
// Directed bench for adder_seq at WIDTH=32, CHUNK=8 (four slices per operation).
module tb_adder_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic [31:0] inA, inB;
  logic [31:0] ans;
  logic        cout, ovf, busy, done;

  int vectors = 0;
  int errors  = 0;

  adder_seq #(.WIDTH(32), .CHUNK(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .inA   (inA),
    .inB   (inB),
    .ans   (ans),
    .cout  (cout),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Drive a request for one edge; returns at the negedge right after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    inA = a; inB = b; sub = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count negedges until done shows up (bounded), tallying busy cycles on the way.
  task automatic wait_done(output int lat, output int busyCnt);
    lat = 0;
    busyCnt = 0;
    while (!done && lat < 20) begin
      if (busy) busyCnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; sub = 1'b0; inA = 32'd9; inB = 32'd9;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: busy=%b done=%b required 0 0", busy, done);
    end
    vectors++;
    if (ans !== 32'd0 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_result: ans=%h cout=%b ovf=%b required 0 0 0", ans, cout, ovf);
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_start_ignored: busy=%b required 0", busy);
    end
  endtask

  task automatic test_add();
    int lat, bc;
    issue(32'd3, 32'd2, 1'b0);
    wait_done(lat, bc);
    vectors++;
    if (lat !== 4 || bc !== 4) begin
      errors++;
      $display("FAIL add_latency: done after %0d busy %0d required 4 4", lat, bc);
    end
    vectors++;
    if (ans !== 32'd5 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL add_3_2: ans=%h cout=%b ovf=%b required 00000005 0 0", ans, cout, ovf);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || ans !== 32'd5) begin
      errors++;
      $display("FAIL add_hold: done=%b busy=%b ans=%h required 0 0 00000005", done, busy, ans);
    end
  endtask

  task automatic test_carry();
    int lat, bc;
    issue(32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_done(lat, bc);
    vectors++;
    if (lat !== 4 || ans !== 32'd0 || cout !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL carry_wrap: lat=%0d ans=%h cout=%b ovf=%b required 4 00000000 1 0",
               lat, ans, cout, ovf);
    end
    issue(32'h0000_00FF, 32'd1, 1'b0);
    wait_done(lat, bc);
    vectors++;
    if (ans !== 32'h100 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL carry_slice: ans=%h cout=%b ovf=%b required 00000100 0 0", ans, cout, ovf);
    end
  endtask

  task automatic test_overflow();
    int lat, bc;
    logic [31:0] expPos, expNeg;
`ifdef ADDER_SEQ_SAT_EN
    expPos = 32'h7FFF_FFFF;
    expNeg = 32'h8000_0000;
`else
    expPos = 32'h8000_0000;
    expNeg = 32'h7FFF_FFFF;
`endif
    issue(32'h7FFF_FFFF, 32'd1, 1'b0);
    wait_done(lat, bc);
    vectors++;
    if (ans !== expPos || cout !== 1'b0 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_pos: ans=%h cout=%b ovf=%b required %h 0 1", ans, cout, ovf, expPos);
    end
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_done(lat, bc);
    vectors++;
    if (ans !== expNeg || cout !== 1'b1 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_neg: ans=%h cout=%b ovf=%b required %h 1 1", ans, cout, ovf, expNeg);
    end
  endtask

  task automatic test_sub();
    int lat, bc;
    logic [31:0] expSubOvf;
`ifdef ADDER_SEQ_SAT_EN
    expSubOvf = 32'h8000_0000;
`else
    expSubOvf = 32'h7FFF_FFFF;
`endif
    issue(32'd3, 32'd5, 1'b1);
    wait_done(lat, bc);
    vectors++;
    if (ans !== 32'hFFFF_FFFE || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL sub_3_5: ans=%h cout=%b ovf=%b required fffffffe 0 0", ans, cout, ovf);
    end
    issue(32'd5, 32'd3, 1'b1);
    wait_done(lat, bc);
    vectors++;
    if (ans !== 32'd2 || cout !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL sub_5_3: ans=%h cout=%b ovf=%b required 00000002 1 0", ans, cout, ovf);
    end
    issue(32'h8000_0000, 32'd1, 1'b1);
    wait_done(lat, bc);
    vectors++;
    if (ans !== expSubOvf || cout !== 1'b1 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL sub_ovf: ans=%h cout=%b ovf=%b required %h 1 1", ans, cout, ovf, expSubOvf);
    end
  endtask

  task automatic test_busy_ignore();
    int lat, bc;
    issue(32'd10, 32'd20, 1'b0);
    @(negedge clk);
    start = 1'b1; inA = 32'd99; inB = 32'd99; sub = 1'b1;
    @(negedge clk);
    start = 1'b0; inA = 32'd5; inB = 32'd5;
    wait_done(lat, bc);
    vectors++;
    if (lat + 2 !== 4 || ans !== 32'd30 || cout !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore: lat=%0d ans=%h cout=%b required 4 0000001e 0",
               lat + 2, ans, cout);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    issue(32'd1, 32'd1, 1'b0);
    wait_done(lat, bc);
    start = 1'b1; inA = 32'd100; inB = 32'd7; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0 || ans !== 32'd2) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b done=%b ans=%h required 1 0 00000002", busy, done, ans);
    end
    wait_done(lat, bc);
    vectors++;
    if (lat !== 4 || ans !== 32'd107) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d ans=%h required 4 0000006b", lat, ans);
    end
  endtask

  task automatic test_reset_abort();
    int seen = 0;
    issue(32'd3, 32'd2, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if (busy !== 1'b0 || ans !== 32'd0 || cout !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: busy=%b ans=%h cout=%b required 0 00000000 0", busy, ans, cout);
    end
    for (int i = 0; i < 8; i++) begin
      if (done) seen++;
      @(negedge clk);
    end
    vectors++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_no_done: done pulses=%0d required 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_carry();
    test_overflow();
    test_sub();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/adder_seq.md
ADDER_SEQ -- requirements
Module: adder_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand and result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 8, bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port start  input  1  request a new operation.
REQ-006 The block SHALL have port sub  input  1  0 = inA+inB, 1 = inA-inB; sampled with start.
REQ-007 The block SHALL have ports inA, inB  input  WIDTH  operands; sampled with start.
REQ-008 The block SHALL have port ans  output  WIDTH  registered result.
REQ-009 The block SHALL have port cout  output  1  carry out of MSB (for sub: 1 = no borrow).
REQ-010 The block SHALL have port ovf  output  1  two's-complement signed overflow.
REQ-011 The block SHALL have port busy  output  1  high while an operation is in progress.
REQ-012 The block SHALL have port done  output  1  one-cycle pulse on result valid.

Function
REQ-013 The block SHALL implement FSM states IDLE, BUSY, DONE; N = WIDTH/CHUNK.
REQ-014 IDLE or DONE with start=1 SHALL latch inA, inB (inB inverted when sub=1), set carry-in = sub, clear chunk counter, go to BUSY.
REQ-015 BUSY SHALL add one CHUNK-bit slice per cycle, LSB slice first, propagating carry to the next slice.
REQ-016 After the Nth slice the FSM SHALL go to DONE; done SHALL be high for exactly the cycle N+1 after the start edge... i.e. exactly N edges after the accepting edge.
REQ-017 ans, cout, ovf SHALL update only at completion (no partial sums visible) and hold until the next completion or reset.
REQ-018 ovf SHALL be set when both effective operand MSBs are equal and the result MSB differs.
REQ-019 start in BUSY SHALL be ignored; operands changing during BUSY SHALL not affect the result.
REQ-020 DONE with start=0 SHALL return to IDLE next cycle; start in DONE SHALL be accepted (back-to-back).
REQ-021 busy SHALL equal (state == BUSY); done SHALL equal (state == DONE).
REQ-022 CHUNK == WIDTH SHALL give N=1 (single-cycle add, result one edge after start).

Reset
REQ-023 rst_n=0 at a clock edge SHALL force IDLE, ans=0, cout=0, ovf=0, busy=0, done=0, counter=0.
REQ-024 Reset during BUSY SHALL abort the operation; no done pulse SHALL follow for it.
REQ-025 start asserted in the same cycle as rst_n=0 SHALL be ignored.

Configuration
REQ-026 Macro ADDER_SEQ_SAT_EN defined SHALL make ans saturate on ovf: positive overflow -> 0111..1, negative -> 1000..0; ovf and cout still reported.
REQ-027 Without ADDER_SEQ_SAT_EN, ans SHALL be the wrapped modulo-2^WIDTH result.

Verification (WIDTH=32, CHUNK=8, N=4)
REQ-028 start, inA=3, inB=2, sub=0 -> done 4 cycles later, ans=5, cout=0, ovf=0, busy high 4 cycles.
REQ-029 inA=0xFFFFFFFF, inB=1 -> ans=0, cout=1, ovf=0.
REQ-030 inA=0x7FFFFFFF, inB=1 -> ovf=1; ans=0x80000000 (no macro), 0x7FFFFFFF (with macro).
REQ-031 sub=1, inA=3, inB=5 -> ans=0xFFFFFFFE, cout=0, ovf=0.
REQ-032 start with new operands during BUSY -> ignored, first result unchanged; start on done cycle -> second result 4 cycles later.
REQ-033 rst_n=0 for one cycle two cycles after start -> busy=0, ans=0 next cycle, no done pulse.
